// File: rtl/inst_fetch_mem.sv
// Byte-addressed, little-endian instruction memory for the IF stage.
// It has a byte-wide program-load port and a one-cycle registered fetch
// that uses valid/ready handshakes on both the request and the response.
// Misaligned and out-of-range fetches return NOP_INST with a fault code.
module inst_fetch_mem #(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [7:0]            prog_data,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [1:0]            resp_fault
);

  // The memory is split into four byte lanes of WORDS entries each.
  // An aligned fetch reads the same word index from every lane.
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Bounds are compared at the full address width.
  // This means high addresses can never alias back into the array.
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_inst_q,  resp_inst_d;
  logic [ADDR_WIDTH-1:0] resp_addr_q,  resp_addr_d;
  logic [1:0]            resp_fault_q, resp_fault_d;

  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_lane;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_byte [4];
  logic [31:0]      rd_word;
  logic             misaligned;
  logic             out_of_range;

  // A new request is taken only when no reset, flush or load is active.
  // The output slot must also be empty or draining this cycle.
  assign req_ready = !reset && !flush && !prog_we && (!resp_valid_q || resp_ready);
  assign accept    = req_valid && req_ready;

  // Writes beyond the array are silently dropped.
  assign wr_en   = prog_we && (prog_addr < DEPTH_LIM);
  assign wr_idx  = prog_addr[IDX_W+1:2];
  assign wr_lane = prog_addr[1:0];
  assign rd_idx  = req_addr[IDX_W+1:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [WORDS];

      // Byte-lane write. Reset does not clear the contents, but it does block loads.
      always_ff @(posedge clk) begin
        if (!reset && wr_en && (wr_lane == 2'(gi))) begin
          mem[wr_idx] <= prog_data;
        end
      end

      assign rd_byte[gi] = mem[rd_idx];
    end
  endgenerate

  assign rd_word      = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = (req_addr > LAST_WORD);

  // Next response state. Flush beats accept, and accept beats drain; otherwise the slot holds.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_inst_d  = resp_inst_q;
    resp_addr_d  = resp_addr_q;
    resp_fault_d = resp_fault_q;
    if (flush) begin
      resp_valid_d = 1'b0;
    end else if (accept) begin
      resp_valid_d = 1'b1;
      resp_addr_d  = req_addr;
      if (misaligned) begin
        resp_fault_d = FAULT_MISALIGN;
        resp_inst_d  = NOP_INST;
      end else if (out_of_range) begin
        resp_fault_d = FAULT_RANGE;
        resp_inst_d  = NOP_INST;
      end else begin
        resp_fault_d = FAULT_OK;
        resp_inst_d  = rd_word;
      end
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Response registers. These provide the one-cycle fetch latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_inst_q  <= '0;
      resp_addr_q  <= '0;
      resp_fault_q <= FAULT_OK;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
      resp_addr_q  <= resp_addr_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_addr  = resp_addr_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed testbench for inst_fetch_mem.
// Covers loading, fetching, stalls, faults, flush, load blocking and reset.
module tb_inst_fetch_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [63:0] prog_addr;
  logic [7:0]  prog_data;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [63:0] resp_addr;
  logic [1:0]  resp_fault;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch_mem #(
    .ADDR_WIDTH (64),
    .DEPTH_BYTES(256),
    .NOP_INST   (32'h00000013)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_inst (resp_inst),
    .resp_addr (resp_addr),
    .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    $display("load  addr=%0d data=%h", a, d);
  endtask

  task automatic chk_resp(input string tag, input logic v, input logic [31:0] inst,
                          input logic [63:0] a, input logic [1:0] f);
    chk({tag, ".valid"}, 64'(resp_valid), 64'(v));
    chk({tag, ".inst"},  64'(resp_inst),  64'(inst));
    chk({tag, ".addr"},  resp_addr,       a);
    chk({tag, ".fault"}, 64'(resp_fault), 64'(f));
    $display("resp  %s valid=%b inst=%h addr=%0d fault=%b", tag, resp_valid, resp_inst, resp_addr, resp_fault);
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    flush = 1'b0; req_valid = 1'b1; req_addr = '0; resp_ready = 1'b0;

    // Reset state; the request must not be accepted while reset is high
    tick();
    #1 chk("rst.req_ready", 64'(req_ready), 64'd0);
    chk_resp("rst", 1'b0, 32'h0, 64'd0, 2'b00);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Program load; address 256 lies outside the array and must not alias to byte 0
    load(64'd0, 8'h83); load(64'd1, 8'h21); load(64'd2, 8'h00); load(64'd3, 8'h00);
    load(64'd4, 8'hB3); load(64'd5, 8'h80); load(64'd6, 8'h01); load(64'd7, 8'h00);
    load(64'd252, 8'h78); load(64'd253, 8'h56); load(64'd254, 8'h34); load(64'd255, 8'h12);
    load(64'd256, 8'hFF);

    // Back-to-back fetch of addresses 0 and 4
    req_valid = 1'b1; req_addr = 64'd0; resp_ready = 1'b1;
    #1 chk("b2b.ready0", 64'(req_ready), 64'd1);
    tick();
    chk_resp("b2b0", 1'b1, 32'h00002183, 64'd0, 2'b00);
    req_addr = 64'd4;
    #1 chk("b2b.ready1", 64'(req_ready), 64'd1);
    tick();
    chk_resp("b2b4", 1'b1, 32'h000180B3, 64'd4, 2'b00);
    req_valid = 1'b0;
    tick();
    chk("drain.valid", 64'(resp_valid), 64'd0);

    // Stall hold: while resp_ready is low the response is held and no request is taken
    req_valid = 1'b1; req_addr = 64'd0; resp_ready = 1'b0;
    tick();
    chk_resp("stall0", 1'b1, 32'h00002183, 64'd0, 2'b00);
    req_addr = 64'd4;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.ready", 64'(req_ready), 64'd0);
      tick();
      chk_resp("stall.hold", 1'b1, 32'h00002183, 64'd0, 2'b00);
    end
    resp_ready = 1'b1;
    #1 chk("stall.release", 64'(req_ready), 64'd1);
    tick();
    chk_resp("stall4", 1'b1, 32'h000180B3, 64'd4, 2'b00);

    // Faults: misaligned addresses take priority over out-of-range ones
    req_addr = 64'd2;   tick(); chk_resp("f2",   1'b1, 32'h00000013, 64'd2,   2'b01);
    req_addr = 64'd254; tick(); chk_resp("f254", 1'b1, 32'h00000013, 64'd254, 2'b01);
    req_addr = 64'd252; tick(); chk_resp("f252", 1'b1, 32'h12345678, 64'd252, 2'b00);
    req_addr = 64'd256; tick(); chk_resp("f256", 1'b1, 32'h00000013, 64'd256, 2'b10);
    req_addr = 64'h0000_0001_0000_0000;
    tick(); chk_resp("fbig", 1'b1, 32'h00000013, 64'h0000_0001_0000_0000, 2'b10);
    req_valid = 1'b0;
    tick();

    // Flush against a held response, with a request in the same cycle
    req_valid = 1'b1; req_addr = 64'd0; resp_ready = 1'b0;
    tick();
    chk("flush.pre", 64'(resp_valid), 64'd1);
    flush = 1'b1; req_addr = 64'd4;
    #1 chk("flush.ready", 64'(req_ready), 64'd0);
    tick();
    chk_resp("flush", 1'b0, 32'h00002183, 64'd0, 2'b00);
    flush = 1'b0; req_valid = 1'b0;
    tick();

    // Load blocking: prog_we suppresses acceptance, and the written word is fetched afterwards
    req_valid = 1'b1; req_addr = 64'd0; resp_ready = 1'b1;
    prog_we = 1'b1; prog_addr = 64'd8; prog_data = 8'h37;
    #1 chk("ldblk.ready", 64'(req_ready), 64'd0);
    tick();
    chk("ldblk.valid", 64'(resp_valid), 64'd0);
    load(64'd9, 8'h05); load(64'd10, 8'h00); load(64'd11, 8'h00);
    req_addr = 64'd8;
    tick();
    chk_resp("ldblk.fetch", 1'b1, 32'h00000537, 64'd8, 2'b00);

    // A held response is not updated by a later write to the same word
    req_valid = 1'b0; resp_ready = 1'b0;
    load(64'd8, 8'h99);
    chk_resp("held.nowrite", 1'b1, 32'h00000537, 64'd8, 2'b00);
    resp_ready = 1'b1;
    tick();

    // Reset during a stall drops the response, and memory is retained afterwards
    req_valid = 1'b1; req_addr = 64'd4; resp_ready = 1'b0;
    tick();
    chk("rstmid.pre", 64'(resp_inst), 64'h000180B3);
    reset = 1'b1;
    #1 chk("rstmid.ready", 64'(req_ready), 64'd0);
    tick();
    chk_resp("rstmid", 1'b0, 32'h0, 64'd0, 2'b00);
    reset = 1'b0; req_addr = 64'd0; resp_ready = 1'b1;
    #1 chk("rstmid.ready1", 64'(req_ready), 64'd1);
    tick();
    chk_resp("rstmid.fetch", 1'b1, 32'h00002183, 64'd0, 2'b00);
    req_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_mem.md
Name: inst_fetch_mem

Overview:
- Parametrised, byte-addressed, little-endian instruction memory with a registered one-cycle read and a valid/ready fetch handshake.
- Has a byte-wide program-load port, so no program is hard-coded.
- Sits between the PC/IF-stage logic and the IF/ID pipeline register.
- Supports stall hold, flush, and fault reporting for misaligned and out-of-range fetches.

Parameters:
- ADDR_WIDTH, 64, width of fetch and load addresses.
- DEPTH_BYTES, 256, memory size in bytes. Must be a multiple of 4 and at least 8.
- NOP_INST, 32'h00000013, word returned on a faulted fetch (addi x0 x0 0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- prog_we  input  1  program-load byte write enable
- prog_addr  input  ADDR_WIDTH  byte address for load
- prog_data  input  8  byte to write
- flush  input  1  discard the pending response and any same-cycle request
- req_valid  input  1  fetch request valid
- req_ready  output  1  fetch request accepted this cycle
- req_addr  input  ADDR_WIDTH  byte address of the instruction
- resp_valid  output  1  response valid
- resp_ready  input  1  consumer accepts the response
- resp_inst  output  32  instruction {M[a+3],M[a+2],M[a+1],M[a]}
- resp_addr  output  ADDR_WIDTH  address of the returned instruction
- resp_fault  output  2  00 ok, 01 misaligned, 10 out of range

Behaviour:
- Reset is synchronous, active-high, on clk rising edge. resp_valid=0, resp_inst=0, resp_addr=0, resp_fault=0.
- Memory array contents are not cleared by reset. Bytes never loaded read as X in simulation.
- req_ready = !reset && !flush && !prog_we && (!resp_valid || resp_ready). It is combinational.
- Accept: req_valid && req_ready at edge N. At edge N+1 resp_valid=1, resp_addr=req_addr, and resp_inst/resp_fault are computed from the state at edge N. Latency is exactly 1 cycle; throughput is 1 word per cycle when resp_ready is held 1.
- Stall: when resp_valid && !resp_ready, resp_valid, resp_inst, resp_addr and resp_fault hold unchanged and req_ready=0.
- Drain: when resp_valid && resp_ready and no accept, resp_valid goes to 0 at the next edge.
- Flush:
  - resp_valid goes to 0 at the next edge regardless of resp_ready.
  - A request presented in the same cycle is not accepted.
  - The other response fields keep their values.
  - Flush wins over a simultaneous accept, hold or drain.
- Program load: prog_we writes prog_data to M[prog_addr] at the edge.
  - prog_addr >= DEPTH_BYTES is ignored; no write and no error.
  - prog_we blocks fetch acceptance, so a load and a read never occur in the same cycle and no bypass is needed.
  - A response already held is not updated by a later write.
- Fault evaluation on accepted req_addr, at full ADDR_WIDTH with no truncation or wrap:
  - req_addr[1:0] != 0 gives fault 01 and resp_inst=NOP_INST. Misaligned has priority over out of range.
  - Aligned but req_addr > DEPTH_BYTES-4 gives fault 10 and resp_inst=NOP_INST.
  - Otherwise fault 00 and resp_inst is the little-endian word.
- A faulted fetch still handshakes normally: resp_valid=1 and it follows the same hold/drain rules.
- Reset asserted mid-stall drops the held response. req_ready=0 during reset. Memory contents are retained, so fetch resumes on the first cycle after reset deasserts.
- Reset has priority over flush, prog_we and accept.

Test Plan:
- Load and fetch. Load bytes 83,21,00,00 at addresses 0..3 and B3,80,01,00 at 4..7 via prog_we, then fetch addresses 0 and 4 with resp_ready=1.
  - Required: resp_inst=32'h00002183 then 32'h000180B3, each one cycle after its accept, back-to-back, fault 00.
- Stall hold. Fetch address 0, hold resp_ready=0 for 3 cycles while req_valid=1 with address 4.
  - Required: resp_inst stays 32'h00002183, resp_addr stays 0, and req_ready=0 throughout.
  - After resp_ready=1: address 4 is accepted and its word appears on the next cycle.
- Faults. Fetch address 2, then DEPTH_BYTES-2 (254), then 252 and 256.
  - Required: fault 01 with NOP 32'h00000013 for address 2 and for 254 (misaligned priority).
  - Required: fault 00 with the loaded word for 252.
  - Required: fault 10 with NOP for 256.
- Flush. Issue flush in the same cycle as a valid response with resp_ready=0 and req_valid=1.
  - Required: resp_valid=0 on the next edge and no request accepted that cycle.
- Load blocking. Assert prog_we and req_valid together.
  - Required: req_ready=0 and the write lands; a following fetch returns the new word.
- Reset mid-operation. Assert reset for 1 cycle while a stalled response is held.
  - Required: all outputs return to 0 and req_ready=0 during reset.
  - Required: a fetch of address 0 after reset returns 32'h00002183 (memory retained).
